adc_udp_packetizer: RTL

Parametrised successor to the fixed 6-channel capture buffer. It captures a triggered block of multi-channel ADC frames into on-chip RAM and serialises the block into byte-wide AXI-stream UDP payload packets with a header-valid handshake, pacing each packet on the MAC's tx_done. The block runs in the 125 MHz Ethernet logic domain; an external CDC FIFO supplies din/din_valid. Over the fixed predecessor it adds:
- configurable channel count, sample width, capture depth and packet size;
- threshold triggering;
- continuous re-arm;
- a short final packet.

---
 rtl/adc_udp_packetizer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_udp_packetizer.sv
// adc_udp_packetizer: captures a triggered block of NUM_CH x SAMPLE_W ADC
// frames into on-chip RAM, then replays it as byte-wide UDP payload packets.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   arm, mode_cont          arm a capture from IDLE / re-arm after readout
//   trig_mode, start        0 = manual start pulse, 1 = threshold on trig_ch
//   trig_ch, trig_level     threshold channel and signed threshold level
//   din_valid, din          one frame per valid cycle, ch0 in the LSBs
//   hdr_valid/hdr_ready     UDP header request with udp_length
//   m_axis_*                byte-wide payload stream, tlast on final byte
//   tx_done                 MAC frame-sent pulse, paces the next packet
//   busy, pkt_count         state != IDLE, packets sent since reset
// Optional feature: define ADC_UDP_SEQ_HDR_EN to prefix every packet with
// the 2-byte big-endian pkt_count value at packet start.
module adc_udp_packetizer #(
    parameter int NUM_CH    = 6,
    parameter int SAMPLE_W  = 16,
    parameter int DEPTH     = 512,
    parameter int PKT_BYTES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         mode_cont,
    input  logic                         trig_mode,
    input  logic [$clog2(NUM_CH)-1:0]    trig_ch,
    input  logic [SAMPLE_W-1:0]          trig_level,
    input  logic                         start,
    input  logic                         din_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   din,
    output logic                         hdr_valid,
    input  logic                         hdr_ready,
    output logic [15:0]                  udp_length,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [15:0]                  pkt_count
);

    localparam int SB      = SAMPLE_W / 8;
    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int TOTAL   = DEPTH * NUM_CH * SB;
    localparam int FA_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SB_W    = (SB > 1) ? $clog2(SB) : 1;
    localparam int BL_W    = $clog2(TOTAL + 1);
    localparam int PL_W    = $clog2(PKT_BYTES + 1);

`ifdef ADC_UDP_SEQ_HDR_EN
    localparam logic [15:0] HDR_LEN = 16'd10;
`else
    localparam logic [15:0] HDR_LEN = 16'd8;
`endif

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HDR     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]                  r_state;
    logic [FA_W-1:0]             r_wr_ptr;
    logic signed [SAMPLE_W-1:0]  r_prev;
    logic                        r_seeded;
    logic [FA_W-1:0]             r_ld_frame;
    logic [CH_W-1:0]             r_ld_ch;
    logic [SB_W-1:0]             r_ld_sb;
    logic [BL_W-1:0]             r_bytes_left;
    logic [PL_W-1:0]             r_pkt_left;
    logic [7:0]                  r_tdata;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic [15:0]                 r_pkt_count;
`ifdef ADC_UDP_SEQ_HDR_EN
    logic [1:0]                  r_pfx;
`endif

    logic [FRAME_W-1:0]          r_mem [DEPTH];
    logic [FRAME_W-1:0]          r_ram_q;

    logic signed [SAMPLE_W-1:0]  w_cur;
    logic                        w_cross;
    logic                        w_fire;
    logic                        w_wr;
    logic                        w_wr_last;
    logic                        w_xfer;
    logic                        w_slot;
    logic                        w_ld_dat;
    logic                        w_ld;
    logic [PL_W-1:0]             w_plen;
    logic [SAMPLE_W-1:0]         w_smp;
    logic [7:0]                  w_dbyte;
    logic [7:0]                  w_byte;
    logic [FA_W-1:0]             w_ld_frame_nxt;
    logic [CH_W-1:0]             w_ld_ch_nxt;
    logic [SB_W-1:0]             w_ld_sb_nxt;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (int'(trig_ch) == i) w_cur = din[i*SAMPLE_W +: SAMPLE_W];
    end

    // The seeding frame only loads r_prev, so it can never fire.
    assign w_cross = r_seeded
                   && (r_prev < $signed(trig_level))
                   && (w_cur >= $signed(trig_level));
    assign w_fire  = din_valid && (trig_mode ? w_cross : start);

    assign w_wr = ((r_state == S_ARMED) && w_fire)
               || ((r_state == S_CAPTURE) && din_valid);
    assign w_wr_last = w_wr && (r_wr_ptr == FA_W'(DEPTH - 1));

    always_comb begin
        if (int'(r_bytes_left) >= PKT_BYTES) w_plen = PL_W'(PKT_BYTES);
        else                                 w_plen = PL_W'(r_bytes_left);
    end

    assign w_xfer = r_tvalid && m_axis_tready;
    assign w_slot = !r_tvalid || m_axis_tready;

`ifdef ADC_UDP_SEQ_HDR_EN
    logic w_ld_pfx;
    assign w_ld_pfx = (r_state == S_PAYLOAD) && (r_pfx != 2'd0) && w_slot;
    assign w_ld_dat = (r_state == S_PAYLOAD) && (r_pfx == 2'd0)
                   && (r_pkt_left != '0) && w_slot;
    assign w_ld     = w_ld_dat || w_ld_pfx;
    assign w_byte   = !w_ld_pfx        ? w_dbyte :
                      (r_pfx == 2'd2)  ? r_pkt_count[15:8] :
                                         r_pkt_count[7:0];
`else
    assign w_ld_dat = (r_state == S_PAYLOAD) && (r_pkt_left != '0) && w_slot;
    assign w_ld     = w_ld_dat;
    assign w_byte   = w_dbyte;
`endif

    always_comb begin
        w_smp = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(r_ld_ch) == c) w_smp = r_ram_q[c*SAMPLE_W +: SAMPLE_W];
        w_dbyte = '0;
        for (int b = 0; b < SB; b++)
            if (int'(r_ld_sb) == b) w_dbyte = w_smp[(SB-1-b)*8 +: 8];
    end

    // Next read position; the RAM is addressed with it so that r_ram_q
    // always holds the frame of the byte about to be loaded.
    always_comb begin
        w_ld_frame_nxt = r_ld_frame;
        w_ld_ch_nxt    = r_ld_ch;
        w_ld_sb_nxt    = r_ld_sb;
        if (r_state == S_IDLE) begin
            w_ld_frame_nxt = '0;
            w_ld_ch_nxt    = '0;
            w_ld_sb_nxt    = '0;
        end else if (w_ld_dat) begin
            if (int'(r_ld_sb) == SB - 1) begin
                w_ld_sb_nxt = '0;
                if (int'(r_ld_ch) == NUM_CH - 1) begin
                    w_ld_ch_nxt    = '0;
                    w_ld_frame_nxt = r_ld_frame + FA_W'(1);
                end else begin
                    w_ld_ch_nxt = r_ld_ch + CH_W'(1);
                end
            end else begin
                w_ld_sb_nxt = r_ld_sb + SB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
        r_ram_q <= r_mem[w_ld_frame_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_prev       <= '0;
            r_seeded     <= 1'b0;
            r_ld_frame   <= '0;
            r_ld_ch      <= '0;
            r_ld_sb      <= '0;
            r_bytes_left <= '0;
            r_pkt_left   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_pkt_count  <= '0;
`ifdef ADC_UDP_SEQ_HDR_EN
            r_pfx        <= '0;
`endif
        end else begin
            r_ld_frame <= w_ld_frame_nxt;
            r_ld_ch    <= w_ld_ch_nxt;
            r_ld_sb    <= w_ld_sb_nxt;
            if (w_wr) r_wr_ptr <= r_wr_ptr + FA_W'(1);

            if (w_ld) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_byte;
                r_tlast  <= w_ld_dat && (r_pkt_left == PL_W'(1));
            end else if (w_xfer) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (w_ld_dat) r_pkt_left <= r_pkt_left - PL_W'(1);
`ifdef ADC_UDP_SEQ_HDR_EN
            if (w_ld_pfx) r_pfx <= r_pfx - 2'd1;
`endif

            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state      <= S_ARMED;
                        r_seeded     <= 1'b0;
                        r_wr_ptr     <= '0;
                        r_bytes_left <= BL_W'(TOTAL);
                    end
                end
                S_ARMED: begin
                    if (din_valid) begin
                        r_prev   <= w_cur;
                        r_seeded <= 1'b1;
                    end
                    if (w_wr) r_state <= w_wr_last ? S_HDR : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_wr_last) r_state <= S_HDR;
                end
                S_HDR: begin
                    if (hdr_ready) begin
                        r_state      <= S_PAYLOAD;
                        r_pkt_left   <= w_plen;
                        r_bytes_left <= r_bytes_left - BL_W'(w_plen);
`ifdef ADC_UDP_SEQ_HDR_EN
                        r_pfx        <= 2'd2;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer && r_tlast) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        r_pkt_count <= r_pkt_count + 16'd1;
                        if (r_bytes_left != '0) begin
                            r_state <= S_HDR;
                        end else if (mode_cont) begin
                            r_state      <= S_ARMED;
                            r_seeded     <= 1'b0;
                            r_wr_ptr     <= '0;
                            r_bytes_left <= BL_W'(TOTAL);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hdr_valid     = (r_state == S_HDR);
    assign udp_length    = hdr_valid ? (16'(w_plen) + HDR_LEN) : 16'd0;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != S_IDLE);
    assign pkt_count     = r_pkt_count;

endmodule
